// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : UART data width, RX/TX state encodings and a counter-width
//               helper shared by the relay and the TX core.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic int bit_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : 8N1 UART serialiser with a registered line output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      start,
    output logic                      busy,
    output logic                      tx
);

    localparam int CNT_W = bit_cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_data_last = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [BIT_W-1:0]          r_bit, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                      r_tx, w_tx_nxt;
    logic                      w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_bit_end   = (r_cnt == c_bit_last);
        case (r_state)
            TX_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (start) begin
                    w_state_nxt = TX_START;
                    w_shift_nxt = data;
                    w_tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_state_nxt = TX_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == c_data_last) begin
                        w_state_nxt = TX_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_shift_nxt = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = TX_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    assign busy = (r_state != TX_IDLE);
    assign tx   = r_tx;

endmodule
`default_nettype wire

// File: rtl/target_uart_relay.sv
`default_nettype none
// ============================================================================
// Module      : target_uart_relay
// Description : Target-to-host UART return path: deserialise, queue, reserialise.
// Revision    : 1.0 - initial release
// ============================================================================
module target_uart_relay
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      target_rx,
    output logic                      uart_tx,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      overflow,
    output logic [7:0]                frame_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CNT_W = bit_cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] c_data_last = BIT_W'(UART_DATA_BITS - 1);

    logic                      r_rx_meta, r_rxs;
    rx_state_t                 r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0]          r_rx_cnt, w_rx_cnt_nxt;
    logic [BIT_W-1:0]          r_rx_bit, w_rx_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                      w_push, w_frame_err;
    logic                      r_rx_valid, r_overflow;
    logic [UART_DATA_BITS-1:0] r_rx_byte;
    logic [7:0]                r_frame_err_cnt;

    logic [UART_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]          r_level;
    logic                      w_full, w_empty, w_wr, w_rd;
    logic                      w_tx_busy, w_tx_idle;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= target_rx;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state      <= RX_IDLE;
            r_rx_cnt        <= '0;
            r_rx_bit        <= '0;
            r_rx_shift      <= '0;
            r_rx_valid      <= 1'b0;
            r_rx_byte       <= '0;
            r_overflow      <= 1'b0;
            r_frame_err_cnt <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_valid <= w_push;
            if (w_push)
                r_rx_byte <= r_rx_shift;
            if (w_push && w_full)
                r_overflow <= 1'b1;
            if (w_frame_err && (r_frame_err_cnt != 8'hFF))
                r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_push         = 1'b0;
        w_frame_err    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (!r_rxs) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_bit_nxt   = '0;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = r_rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rxs, r_rx_shift[UART_DATA_BITS-1:1]};
                    if (r_rx_bit == c_data_last)
                        w_rx_state_nxt = RX_STOP;
                    else
                        w_rx_bit_nxt = r_rx_bit + BIT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rxs) begin
                        w_push         = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_frame_err    = 1'b1;
                        w_rx_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                w_rx_cnt_nxt = '0;
                if (r_rxs)
                    w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is dropped even while the TX side is draining it.
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_tx_idle = ~w_tx_busy;
    assign w_wr      = w_push && !w_full;
    assign w_rd      = !w_empty && w_tx_idle;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_core (
        .clk   (clk),
        .rst   (rst),
        .data  (r_mem[r_rd_ptr]),
        .start (w_rd),
        .busy  (w_tx_busy),
        .tx    (uart_tx)
    );

    assign rx_valid      = r_rx_valid;
    assign rx_byte       = r_rx_byte;
    assign overflow      = r_overflow;
    assign frame_err_cnt = r_frame_err_cnt;
    assign fifo_level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_target_uart_relay.sv
`default_nettype none
// ============================================================================
// Module      : tb_target_uart_relay
// Description : Directed scoreboard bench for target_uart_relay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_target_uart_relay;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             target_rx = 1'b1;
    logic             uart_tx;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             overflow;
    logic [7:0]       frame_err_cnt;
    logic [LVL_W-1:0] fifo_level;

    target_uart_relay #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .target_rx    (target_rx),
        .uart_tx      (uart_tx),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .overflow     (overflow),
        .frame_err_cnt(frame_err_cnt),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    longint     cyc = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int         rx_cnt = 0;
    int         tx_frames = 0;
    longint     last_rx_cyc = 0;
    longint     last_tx_cyc = 0;
    int         max_level = 0;
    bit         tx_active = 1'b0;
    logic [9:0] tx_early, tx_late;
    bit         tx_abort;
    logic [7:0] tx_exp_byte;
    logic [7:0] pat [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RX-side scoreboard: every rx_valid pulse pops one expected byte
    initial forever begin
        @(negedge clk);
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            last_rx_cyc = cyc;
            if (exp_rx.size() == 0)
                check("rx_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
            else
                check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
        end
    end

    // TX-side scoreboard: samples the first and last cycle of every bit slot
    initial forever begin
        @(negedge clk);
        if (!rst && uart_tx === 1'b0) begin
            tx_active   = 1'b1;
            tx_abort    = 1'b0;
            last_tx_cyc = cyc;
            for (int b = 0; b < 10 && !tx_abort; b++) begin
                tx_early[b] = uart_tx;
                for (int k = 0; k < CPB - 1 && !tx_abort; k++) begin
                    @(negedge clk);
                    if (rst) tx_abort = 1'b1;
                end
                tx_late[b] = uart_tx;
                if (b < 9 && !tx_abort) begin
                    @(negedge clk);
                    if (rst) tx_abort = 1'b1;
                end
            end
            if (!tx_abort) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 32'(tx_late), 32'hFFFF_FFFF);
                end else begin
                    tx_exp_byte = exp_tx.pop_front();
                    check("tx_frame_early", 32'(tx_early), 32'({1'b1, tx_exp_byte, 1'b0}));
                    check("tx_frame_late", 32'(tx_late), 32'({1'b1, tx_exp_byte, 1'b0}));
                end
                tx_frames++;
            end
            tx_active = 1'b0;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        logic [9:0] f;
        f = {stop_val, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            target_rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        target_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_rx.push_back(b);
        exp_tx.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0 || tx_active) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < max_cyc), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx_low(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_timeout"}, 32'(n < max_cyc), 32'd1);
    endtask

    initial begin
        int snap;
        rst = 1'b1;
        target_rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(frame_err_cnt), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;

        // single byte, latency and bit timing
        rx_cnt = 0;
        send_byte(8'h55);
        wait_drain("single", 400);
        check("single_rx_count", 32'(rx_cnt), 32'd1);
        // rx_valid is one cycle after the stop sample; uart_tx falls one later
        check("single_latency", 32'(last_tx_cyc - last_rx_cyc), 32'd1);

        // back-to-back frames
        max_level = 0;
        for (int i = 0; i < 4; i++) send_byte(pat[i]);
        wait_drain("b2b", 1000);
        check("b2b_peak_le2", 32'(max_level <= 2), 32'd1);
        check("b2b_overflow", 32'(overflow), 32'd0);

        // glitch rejection
        snap = rx_cnt;
        @(posedge clk); #1;
        target_rx = 1'b0;
        repeat (5) @(posedge clk); #1;
        target_rx = 1'b1;
        repeat (200) @(posedge clk); #1;
        check("glitch_rx_count", 32'(rx_cnt), 32'(snap));
        check("glitch_ferr", 32'(frame_err_cnt), 32'd0);
        check("glitch_level", 32'(fifo_level), 32'd0);

        // framing error followed by a line held low, then a good byte
        snap = rx_cnt;
        send_frame(8'h81, 1'b0);
        target_rx = 1'b0;
        repeat (40) @(posedge clk); #1;
        target_rx = 1'b1;
        repeat (32) @(posedge clk); #1;
        check("ferr_count", 32'(frame_err_cnt), 32'd1);
        check("ferr_no_rx", 32'(rx_cnt), 32'(snap));
        check("ferr_level", 32'(fifo_level), 32'd0);
        send_byte(8'h42);
        wait_drain("ferr", 600);
        check("ferr_count_after", 32'(frame_err_cnt), 32'd1);

        // overflow: TX held off after the first byte starts draining
        max_level = 0;
        send_byte(8'h01);
        wait_tx_low("ovf", 200);
        force u_dut.w_tx_idle = 1'b0;
        for (int i = 2; i <= 5; i++) send_byte(8'(i));
        exp_rx.push_back(8'h06);
        send_frame(8'h06, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level_full", 32'(fifo_level), 32'd4);
        release u_dut.w_tx_idle;
        wait_drain("ovf", 1500);
        check("ovf_peak_eq4", 32'(max_level), 32'd4);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // reset in the middle of a frame with two bytes queued
        force u_dut.w_tx_idle = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (4) @(posedge clk); #1;
        release u_dut.w_tx_idle;
        wait_tx_low("rstmid", 50);
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_uart_tx", 32'(uart_tx), 32'd1);
        check("rstmid_level", 32'(fifo_level), 32'd0);
        check("rstmid_overflow", 32'(overflow), 32'd0);
        check("rstmid_ferr", 32'(frame_err_cnt), 32'd0);
        check("rstmid_rx_byte", 32'(rx_byte), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_tx.delete();
        exp_rx.delete();
        repeat (10) @(posedge clk); #1;
        send_byte(8'h99);
        wait_drain("post_rst", 400);
        check("post_rst_rx_byte", 32'(rx_byte), 32'h99);

        repeat (50) @(negedge clk);
        check("tx_frame_total", 32'(tx_frames), 32'd12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        bad++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/target_uart_relay.md
Name: target_uart_relay

Overview:
- Buffered return path from target to host: target MCU UART → FPGA → FTDI-RX.
- Deserialises target_rx and queues complete bytes in a FIFO, then re-serialises them on uart_tx at the same baud.
- Adds framing checks, overflow detection and a byte tap for on-chip logic, e.g. trigger-on-response.
- Sits beside command_processor, which owns the host→target direction, and clocks on sys_clk.

Parameters:
- CLKS_PER_BIT, 868, sys_clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 16, byte entries; power of two, ≥ 2.

Ports:
- clk  in  1  sys_clk
- rst  in  1  synchronous, active-high reset
- target_rx  in  1  target TX line; asynchronous, idle high
- uart_tx  out  1  to FTDI-RX; idle high
- rx_valid  out  1  one-cycle pulse when a byte with a good stop bit is received
- rx_byte  out  8  last good byte; held until the next one
- overflow  out  1  sticky; a byte was dropped because the FIFO was full
- frame_err_cnt  out  8  saturating count of bad stop bits
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: clk is the single clock; reset is synchronous and active-high.
  - rst high forces uart_tx=1, rx_valid=0, rx_byte=0, overflow=0, frame_err_cnt=0, fifo_level=0.
  - Both FSMs go to IDLE and FIFO pointers clear on the next edge.
  - A frame in flight is truncated; a short frame on uart_tx is acceptable.
- Input sync: target_rx passes through 2 flops (reset to 1). All RX logic uses the synchronised value rxs.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxs=0 → START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs. 0 → DATA; 1 → IDLE (glitch rejected, no error counted).
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1 → push to FIFO, rx_byte updates, rx_valid pulses, return to IDLE.
    - rxs=0 → frame_err_cnt++ (saturates at 255), byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: remain until rxs=1, then IDLE. Prevents a break condition being read as back-to-back starts.
- FIFO: synchronous, one push and one pop per cycle.
  - Full is judged on occupancy before any same-cycle pop.
  - Push while full: byte dropped, overflow set. rx_valid/rx_byte still report it.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is exact from 0 to FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop. The next cycle enters START and drives uart_tx=0.
  - Each bit lasts exactly CLKS_PER_BIT cycles; data is LSB first; stop bit = 1.
  - After STOP, return to IDLE. If the FIFO is still non-empty, the next start bit follows with ≤1 idle cycle.
- Latency: with TX idle and FIFO empty, the uart_tx falling edge comes 2 cycles after the RX stop-bit sample cycle.
- uart_tx is registered, so no combinational path from target_rx exists.

Decomposition:
- Shared package uart_pkg holds:
  - localparam UART_DATA_BITS=8;
  - typedef enum for RX states (rx_state_t) and TX states (tx_state_t);
  - function for bit-counter width from CLKS_PER_BIT.
- Sub-module uart_tx_core (clk, rst, data, start, busy, tx). It is reusable by command_processor.
- RX and FIFO stay inline.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4 in simulation):
- Single byte: drive 0x55 frame on target_rx → rx_valid pulses once with rx_byte=0x55. Identical 0x55 frame appears on uart_tx, start edge 2 cycles after the stop sample; each bit exactly 16 cycles.
- Back-to-back 0x00, 0xFF, 0xA5, 0x3C → uart_tx reproduces all 4 in order. fifo_level peaks ≤2; overflow stays 0.
- Overflow: hold TX busy, send 6 bytes 0x01–0x06 with FIFO_DEPTH=4 → overflow=1; uart_tx emits 0x01..0x05 (one drained during fill) and never 0x06; level never exceeds 4.
- Framing: frame 0x81 with stop bit 0, line held low for 40 cycles, then a valid 0x42 → frame_err_cnt=1, no push for 0x81, 0x42 relayed; no spurious byte during the low period.
- Glitch rejection: 5-cycle low pulse on target_rx → no state leaves IDLE after START, rx_valid=0, frame_err_cnt=0.
- Reset mid-operation: assert rst at bit 4 of a TX frame with 2 bytes queued → next cycle uart_tx=1, fifo_level=0, overflow=0, frame_err_cnt=0. A subsequent 0x99 frame relays correctly.
